// File: rtl/cache_controller_burst.sv
// Cache line controller: hit handling, dirty-victim writeback burst, line refill burst
// and optional write-through of CPU stores, with a shared beat counter for both bursts.
module cache_controller_burst #(
    parameter int  WORDS_PER_LINE = 4,
    parameter int  WRITE_THROUGH  = 0,
    localparam int BW             = $clog2(WORDS_PER_LINE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_type,
    input  logic          hit,
    input  logic          dirty_bit,
    input  logic          ready_mem,
    output logic          read_en_mem,
    output logic          write_en_mem,
    output logic          read_en_cache,
    output logic          write_en_cache,
    output logic          refill,
    output logic [BW-1:0] beat_idx,
    output logic          done_cache,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        WRITEBACK = 3'd2,
        ALLOCATE  = 3'd3,
        WT_WRITE  = 3'd4
    } state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS_PER_LINE - 1);
    localparam bit            WT        = (WRITE_THROUGH != 0);

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        read_en_mem    = 1'b0;
        write_en_mem   = 1'b0;
        read_en_cache  = 1'b0;
        write_en_cache = 1'b0;
        refill         = 1'b0;
        done_cache     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    if (!req_type) begin
                        read_en_cache = 1'b1;
                        done_cache    = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        write_en_cache = 1'b1;
                        if (WT) begin
                            state_d = WT_WRITE;
                        end else begin
                            done_cache = 1'b1;
                            state_d    = IDLE;
                        end
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = (dirty_bit && !WT) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                write_en_mem  = 1'b1;
                read_en_cache = 1'b1;
                if (ready_mem) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                read_en_mem = 1'b1;
                refill      = ready_mem;
                if (ready_mem) begin
                    // Counter wraps to zero on the last beat, leaving it clean for the re-compare.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) state_d = COMPARE;
                end
            end
            WT_WRITE: begin
                write_en_mem = 1'b1;
                if (ready_mem) begin
                    done_cache = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign beat_idx = cnt_q;
    assign busy     = (state_q != IDLE);

endmodule
